memory_stage: RTL and testbench

//  EX/MEM pipeline latch plus data-memory access sequencer for the 5-stage MIPS pipeline.

---
 rtl/control_unit_pkg.sv | 15 +
 rtl/cpu_types_pkg.sv | 8 +
 rtl/memory_stage.sv | 171 +++++++++++++++++
 tb/tb_memory_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Control encodings shared by decode, execute and memory stages.
package control_unit_pkg;
  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_LOAD = 2'd1,
    RS_NPC  = 2'd2,
    RS_LUI  = 2'd3
  } regsel_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_DONE = 2'd2
  } memstate_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared across the MIPS pipeline stages.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/memory_stage.sv
// EX/MEM latch plus dcache access sequencer feeding the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN suppresses misaligned accesses and adds the misalign output.
//   state  | meaning
//   M_IDLE | occupant makes no dcache access
//   M_REQ  | request driven, waiting for dhit
//   M_DONE | dhit taken, load data held until the pipeline advances
module memory_stage
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ihit,
  input  logic                   flush,
  input  word_t                  ex_nPC,
  input  logic                   ex_dREN,
  input  logic                   ex_dWEN,
  input  logic                   ex_regWr,
  input  regsel_t                ex_regSel,
  input  regbits_t               ex_regDst,
  input  word_t                  ex_ALUOut,
  input  word_t                  ex_rtdat,
  input  logic                   dhit,
  input  word_t                  dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output word_t                  dmemaddr,
  output word_t                  dmemstore,
  output logic                   mem_stall,
  output word_t                  wb_nPC,
  output logic                   wb_regWr,
  output regsel_t                wb_regSel,
  output regbits_t               wb_regDst,
  output word_t                  wb_ALUOut,
  output word_t                  wb_load,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                   misalign,
`endif
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  memstate_t state, state_next;
  logic      advance;
  logic      new_dren, new_dwen, new_regwr;
  logic      hit_now;

  word_t     em_npc, em_aluout, em_rtdat;
  logic      em_dren, em_dwen, em_regwr;
  regsel_t   em_regsel;
  regbits_t  em_regdst;
  word_t     load_buf;
`ifdef MEM_ALIGN_CHECK_EN
  logic      new_mis, em_mis;
`endif

  assign mem_stall = (state == M_REQ) && !dhit;
  assign advance   = ihit && !mem_stall;
  assign hit_now   = (state == M_REQ) && dhit;

  assign dmemREN   = (state == M_REQ) && em_dren;
  assign dmemWEN   = (state == M_REQ) && em_dwen;
  assign dmemaddr  = em_aluout;
  assign dmemstore = em_rtdat;

  // Both dREN and dWEN set is treated as a store with no register writeback.
  always_comb begin
    new_dren  = ex_dREN && !ex_dWEN && !flush;
    new_dwen  = ex_dWEN && !flush;
    new_regwr = ex_regWr && !(ex_dREN && ex_dWEN) && !flush;
`ifdef MEM_ALIGN_CHECK_EN
    new_mis   = 1'b0;
    if ((new_dren || new_dwen) && (ex_ALUOut[1:0] != 2'b00)) begin
      new_mis   = 1'b1;
      new_dren  = 1'b0;
      new_dwen  = 1'b0;
      new_regwr = 1'b0;
    end
`endif
  end

  always_comb begin
    state_next = state;
    if (advance) begin
      state_next = (new_dren || new_dwen) ? M_REQ : M_IDLE;
    end else if (hit_now) begin
      state_next = M_DONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= M_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      em_npc    <= '0;
      em_dren   <= 1'b0;
      em_dwen   <= 1'b0;
      em_regwr  <= 1'b0;
      em_regsel <= RS_ALU;
      em_regdst <= '0;
      em_aluout <= '0;
      em_rtdat  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      em_mis    <= 1'b0;
`endif
    end else if (advance) begin
      em_npc    <= ex_nPC;
      em_dren   <= new_dren;
      em_dwen   <= new_dwen;
      em_regwr  <= new_regwr;
      em_regsel <= ex_regSel;
      em_regdst <= ex_regDst;
      em_aluout <= ex_ALUOut;
      em_rtdat  <= ex_rtdat;
`ifdef MEM_ALIGN_CHECK_EN
      em_mis    <= new_mis;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_buf <= '0;
    end else if (hit_now) begin
      load_buf <= dmemload;
    end
  end

  // A hit coinciding with advance bypasses the load buffer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_nPC    <= '0;
      wb_regWr  <= 1'b0;
      wb_regSel <= RS_ALU;
      wb_regDst <= '0;
      wb_ALUOut <= '0;
      wb_load   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else if (advance) begin
      wb_nPC    <= em_npc;
      wb_regWr  <= em_regwr;
      wb_regSel <= em_regsel;
      wb_regDst <= em_regdst;
      wb_ALUOut <= em_aluout;
      wb_load   <= hit_now ? dmemload : load_buf;
`ifdef MEM_ALIGN_CHECK_EN
      misalign  <= em_mis;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage; honours MEM_ALIGN_CHECK_EN when defined.
module tb_memory_stage;
  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, flush, ex_dREN, ex_dWEN, ex_regWr, dhit;
  regsel_t       ex_regSel;
  regbits_t      ex_regDst;
  word_t         ex_nPC, ex_ALUOut, ex_rtdat, dmemload;
  logic          dmemREN, dmemWEN, mem_stall, wb_regWr;
  word_t         dmemaddr, dmemstore, wb_nPC, wb_ALUOut, wb_load;
  regsel_t       wb_regSel;
  regbits_t      wb_regDst;
  logic [CW-1:0] stall_cycles;
`ifdef MEM_ALIGN_CHECK_EN
  logic          misalign;
`endif

  always #5 CLK = ~CLK;

  memory_stage #(.STALL_CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
    .ex_nPC(ex_nPC), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr),
    .ex_regSel(ex_regSel), .ex_regDst(ex_regDst), .ex_ALUOut(ex_ALUOut), .ex_rtdat(ex_rtdat),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_nPC(wb_nPC), .wb_regWr(wb_regWr), .wb_regSel(wb_regSel),
    .wb_regDst(wb_regDst), .wb_ALUOut(wb_ALUOut), .wb_load(wb_load),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic ren, wen, regwr;
    regsel_t sel;
    logic [4:0] dst;
    logic [31:0] npc, alu, rt;
  } instr_t;

  // Instruction sitting between execute and writeback, as the pipeline sees it.
  typedef struct packed {
    logic live, ren, wen, regwr, pending, mis;
    regsel_t sel;
    logic [4:0] dst;
    logic [31:0] npc, alu, rt;
  } occ_t;

  typedef struct packed {
    logic ren, wen, stall;
    logic [31:0] addr, store;
  } comb_exp_t;

  typedef struct packed {
    logic live, regwr;
    regsel_t sel;
    logic [4:0] dst;
    logic [31:0] npc, alu, load;
    logic mis;
    logic [CW-1:0] cnt;
  } wb_exp_t;

  comb_exp_t   cq[$];
  wb_exp_t     sq[$];
  occ_t        occ;
  wb_exp_t     wbm;
  logic [31:0] loadbuf;
  int          cnt;
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    occ      = '0;
    occ.live = 1'b1;
    wbm      = '0;
    wbm.live = 1'b1;
    loadbuf  = '0;
    cnt      = 0;
  endtask

  function automatic instr_t mk(input logic r, input logic w, input logic rw, input logic [31:0] a);
    instr_t i;
    i.ren = r; i.wen = w; i.regwr = rw; i.alu = a;
    i.sel = regsel_t'(2'($urandom));
    i.dst = 5'($urandom);
    i.npc = $urandom;
    i.rt  = $urandom;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    int k;
    k = $urandom_range(0, 9);
    return mk(k inside {4, 5, 8}, k inside {6, 7, 8}, !(k inside {6, 7, 9}), $urandom);
  endfunction

  // One pipeline cycle: drive inputs and predict what the stage must show.
  task automatic step(input logic ih, input logic fl, input instr_t in, input logic dh, input logic [31:0] ld);
    comb_exp_t ce;
    logic stall, adv;
    @(negedge CLK);
    ihit = ih; flush = fl; dhit = dh; dmemload = ld;
    ex_dREN = in.ren; ex_dWEN = in.wen; ex_regWr = in.regwr; ex_regSel = in.sel;
    ex_regDst = in.dst; ex_nPC = in.npc; ex_ALUOut = in.alu; ex_rtdat = in.rt;
    stall = occ.pending && !dh;
    ce.ren = occ.pending && occ.ren;
    ce.wen = occ.pending && occ.wen;
    ce.stall = stall;
    ce.addr = occ.alu;
    ce.store = occ.rt;
    cq.push_back(ce);
    if (stall && cnt < (1 << CW) - 1) cnt++;
    adv = ih && !stall;
    if (occ.pending && dh) loadbuf = ld;
    if (adv) begin
      wbm.live = occ.live; wbm.regwr = occ.regwr; wbm.sel = occ.sel; wbm.dst = occ.dst;
      wbm.npc = occ.npc; wbm.alu = occ.alu; wbm.load = loadbuf; wbm.mis = occ.mis;
      occ.live = !fl;
      occ.ren = in.ren && !in.wen && !fl;
      occ.wen = in.wen && !fl;
      occ.regwr = in.regwr && !(in.ren && in.wen) && !fl;
      occ.mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if ((occ.ren || occ.wen) && in.alu[1:0] != 2'b00) begin
        occ.mis = 1'b1; occ.ren = 1'b0; occ.wen = 1'b0; occ.regwr = 1'b0;
      end
`endif
      occ.sel = in.sel; occ.dst = in.dst; occ.npc = in.npc; occ.alu = in.alu; occ.rt = in.rt;
      occ.pending = occ.ren || occ.wen;
    end else if (occ.pending && dh) begin
      occ.pending = 1'b0;
    end
    wbm.cnt = CW'(cnt);
    sq.push_back(wbm);
  endtask

  task automatic rst_checks();
    chk("rst_req", {dmemREN, dmemWEN, mem_stall}, 3'b000);
    chk("rst_wb", {wb_nPC, wb_regWr, wb_regSel, wb_regDst, wb_ALUOut, wb_load}, '0);
    chk("rst_cnt", stall_cycles, '0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_misalign", misalign, 1'b0);
`endif
  endtask

  // Reset pulsed in the middle of a cycle while an access may be outstanding.
  task automatic mid_reset();
    @(negedge CLK);
    ihit = 1'b0; dhit = 1'b0; flush = 1'b0;
    #2;
    chk("pre_rst_dmemREN", dmemREN, occ.pending && occ.ren);
    #2;
    nRST = 1'b0;
    #1;
    rst_checks();
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin : comb_monitor
    comb_exp_t ce;
    forever begin
      @(negedge CLK);
      #2;
      if (cq.size() != 0) begin
        ce = cq.pop_front();
        chk("dmem_req_stall", {dmemREN, dmemWEN, mem_stall}, {ce.ren, ce.wen, ce.stall});
        if (ce.ren || ce.wen) begin
          chk("dmemaddr", dmemaddr, ce.addr);
          chk("dmemstore", dmemstore, ce.store);
        end
      end
    end
  end

  initial begin : wb_monitor
    wb_exp_t we;
    forever begin
      @(posedge CLK);
      #1;
      if (sq.size() != 0) begin
        we = sq.pop_front();
        chk("wb_regWr", wb_regWr, we.regwr);
        if (we.live) chk("wb_fields", {wb_nPC, wb_regSel, wb_regDst, wb_ALUOut}, {we.npc, we.sel, we.dst, we.alu});
        chk("wb_load", wb_load, we.load);
        chk("stall_cycles", stall_cycles, we.cnt);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign", misalign, we.mis);
`endif
      end
    end
  end

  initial begin
    instr_t nop;
    nRST = 1'b0; ihit = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = '0;
    ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_regWr = 1'b0; ex_regSel = RS_ALU;
    ex_regDst = '0; ex_nPC = '0; ex_ALUOut = '0; ex_rtdat = '0;
    model_reset();
    #7;
    rst_checks();
    @(negedge CLK);
    nRST = 1'b1;
    nop = mk(1'b0, 1'b0, 1'b0, 32'h0);

    // ALU op passes straight through
    step(1, 0, mk(0, 0, 1, 32'h0000_1234), 0, $urandom);
    step(1, 0, nop, 0, $urandom);
    step(1, 0, nop, 0, $urandom);

    // load with dhit on the third request cycle
    step(1, 0, mk(1, 0, 1, 32'h0000_0100), 0, $urandom);
    step(1, 0, nop, 0, $urandom);
    step(1, 0, nop, 0, $urandom);
    step(1, 0, nop, 1, 32'hDEAD_BEEF);
    step(1, 0, nop, 0, $urandom);

    // store completes while ihit is low, must not re-issue
    step(1, 0, mk(0, 1, 0, 32'h0000_0200), 0, $urandom);
    step(0, 0, nop, 1, 32'hCAFE_0001);
    step(0, 0, nop, 0, $urandom);
    step(0, 0, nop, 1, 32'hCAFE_0002);
    step(1, 0, nop, 0, $urandom);
    step(1, 0, nop, 0, $urandom);

    // flushed store becomes a bubble
    step(1, 1, mk(0, 1, 1, 32'h0000_0300), 0, $urandom);
    step(1, 0, nop, 0, $urandom);
    step(1, 0, nop, 0, $urandom);

    // illegal load+store behaves as a store without writeback
    step(1, 0, mk(1, 1, 1, 32'h0000_0400), 0, $urandom);
    step(1, 0, nop, 1, 32'h1111_2222);
    step(1, 0, nop, 0, $urandom);

`ifdef MEM_ALIGN_CHECK_EN
    step(1, 0, mk(1, 0, 1, 32'h0000_0102), 0, $urandom);
    step(1, 0, nop, 1, $urandom);
    step(1, 0, nop, 0, $urandom);
`endif

    repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand_instr(),
                       $urandom_range(0, 2) == 0, $urandom);

    // reset while a load request is outstanding
    step(1, 0, mk(1, 0, 1, 32'h0000_0500), 0, $urandom);
    step(0, 0, nop, 0, $urandom);
    mid_reset();
    step(1, 0, mk(0, 0, 1, 32'h0000_0600), 0, $urandom);
    step(1, 0, nop, 0, $urandom);

    repeat (500) step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rand_instr(),
                      $urandom_range(0, 2) == 0, $urandom);

    repeat (3) @(negedge CLK);
    chk("queues_drained", 128'(cq.size() + sq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
